// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with combinational hit path,
// word-serial line refill, true-LRU replacement and global invalidate.
module icache_nway #(
  parameter int unsigned OFFSET_LEN = 5,
  parameter int unsigned INDEX_LEN  = 7,
  parameter int unsigned WAY_CNT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_req,
  output logic [31:0] rd_data,
  output logic        miss,
  input  logic        inv,
  output logic        mem_read_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rlast
);

  localparam int unsigned TAG_LEN  = 32 - INDEX_LEN - OFFSET_LEN;
  localparam int unsigned BEAT_W   = OFFSET_LEN - 2;
  localparam int unsigned WORDS    = 1 << BEAT_W;
  localparam int unsigned SETS     = 1 << INDEX_LEN;
  localparam int unsigned WAY_BITS = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_INSTALL} state_e;

  state_e              state_q;
  logic                pend_inv_q;
  logic [WAY_BITS-1:0] victim_q;
  logic [BEAT_W-1:0]   beat_q;

  logic [TAG_LEN-1:0]  tag_q   [WAY_CNT][SETS];
  logic [31:0]         data_q  [WAY_CNT][SETS][WORDS];
  logic                valid_q [SETS][WAY_CNT];
  logic [WAY_BITS-1:0] age_q   [SETS][WAY_CNT];

  logic [TAG_LEN-1:0]   tag;
  logic [INDEX_LEN-1:0] idx;
  logic [BEAT_W-1:0]    word;
  logic                 unused_addr_bits;

  assign tag              = addr[31:OFFSET_LEN+INDEX_LEN];
  assign idx              = addr[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN];
  assign word             = addr[OFFSET_LEN-1:2];
  assign unused_addr_bits = ^addr[1:0];

  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  logic [WAY_BITS-1:0] victim_d;
  logic                refill_start;
  logic                flush;
  logic                lru_en;
  logic [WAY_BITS-1:0] lru_way;

  // Lookup, victim choice and update controls; loops run high-to-low so the lowest way wins.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    victim_d = '0;
    for (int i = int'(WAY_CNT) - 1; i >= 0; i--) begin
      if (valid_q[idx][i] && (tag_q[i][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(i);
      end
    end
    for (int i = int'(WAY_CNT) - 1; i >= 0; i--) begin
      if (age_q[idx][i] == WAY_BITS'(WAY_CNT - 1)) victim_d = WAY_BITS'(i);
    end
    for (int i = int'(WAY_CNT) - 1; i >= 0; i--) begin
      if (!valid_q[idx][i]) victim_d = WAY_BITS'(i);
    end
    // A flush on the miss edge empties the set, so the first way is the victim.
    if (inv) victim_d = '0;

    refill_start = (state_q == S_IDLE) && rd_req && !hit;
    flush        = ((state_q == S_IDLE) && inv) ||
                   ((state_q == S_INSTALL) && (pend_inv_q || inv));
    lru_en       = ((state_q == S_IDLE) && rd_req && hit) || (state_q == S_INSTALL);
    lru_way      = (state_q == S_INSTALL) ? victim_q : hit_way;
  end

  assign rd_data      = hit ? data_q[hit_way][idx][word] : 32'h0;
  assign miss         = (state_q != S_IDLE) || (rd_req && !hit);
  assign mem_read_req = (state_q == S_REFILL);
  assign mem_addr     = mem_read_req ? {addr[31:OFFSET_LEN], OFFSET_LEN'(0)} : 32'h0;

  // Control FSM plus valid and age arrays.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_inv_q <= 1'b0;
      victim_q   <= '0;
      beat_q     <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAY_CNT); w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_BITS'(w);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (refill_start) begin
            state_q  <= S_REFILL;
            victim_q <= victim_d;
            beat_q   <= '0;
          end
        end
        S_REFILL: begin
          if (inv) pend_inv_q <= 1'b1;
          if (mem_rvalid) begin
            beat_q <= beat_q + 1'b1;
            if (mem_rlast) state_q <= S_INSTALL;
          end
        end
        S_INSTALL: begin
          state_q    <= S_IDLE;
          pend_inv_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (flush) begin
        for (int s = 0; s < int'(SETS); s++) begin
          for (int w = 0; w < int'(WAY_CNT); w++) begin
            valid_q[s][w] <= 1'b0;
            age_q[s][w]   <= WAY_BITS'(w);
          end
        end
      end else begin
        if (refill_start) valid_q[idx][victim_d] <= 1'b0;
        if (state_q == S_INSTALL) valid_q[idx][victim_q] <= 1'b1;
        if (lru_en) begin
          for (int w = 0; w < int'(WAY_CNT); w++) begin
            if (WAY_BITS'(w) == lru_way) begin
              age_q[idx][w] <= '0;
            end else if (age_q[idx][w] < age_q[idx][lru_way]) begin
              age_q[idx][w] <= age_q[idx][w] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Line data and tags carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if ((state_q == S_REFILL) && mem_rvalid) data_q[victim_q][idx][beat_q] <= mem_rdata;
    if (state_q == S_INSTALL) tag_q[victim_q][idx] <= tag;
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: a 2-way default instance and a 4-way/16-set instance,
// each fed by a word-serial memory model, with a scoreboard of expected fetch results.
module tb_icache_nway;

  logic        clk;
  logic        rst          [2];
  logic [31:0] addr         [2];
  logic        rd_req       [2];
  logic        inv          [2];
  logic        mem_rvalid   [2];
  logic [31:0] mem_rdata    [2];
  logic        mem_rlast    [2];
  logic [31:0] rd_data      [2];
  logic        miss         [2];
  logic        mem_read_req [2];
  logic [31:0] mem_addr     [2];

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [31:0] exp_q [$];

  icache_nway u_dut2 (
    .clk          (clk),
    .rst          (rst[0]),
    .addr         (addr[0]),
    .rd_req       (rd_req[0]),
    .rd_data      (rd_data[0]),
    .miss         (miss[0]),
    .inv          (inv[0]),
    .mem_read_req (mem_read_req[0]),
    .mem_addr     (mem_addr[0]),
    .mem_rvalid   (mem_rvalid[0]),
    .mem_rdata    (mem_rdata[0]),
    .mem_rlast    (mem_rlast[0])
  );

  icache_nway #(.INDEX_LEN(4), .WAY_CNT(4)) u_dut4 (
    .clk          (clk),
    .rst          (rst[1]),
    .addr         (addr[1]),
    .rd_req       (rd_req[1]),
    .rd_data      (rd_data[1]),
    .miss         (miss[1]),
    .inv          (inv[1]),
    .mem_read_req (mem_read_req[1]),
    .mem_addr     (mem_addr[1]),
    .mem_rvalid   (mem_rvalid[1]),
    .mem_rdata    (mem_rdata[1]),
    .mem_rlast    (mem_rlast[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory contents; line 0x1000 holds 0xA0..0xA7.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
    if (line == 32'h0000_1000) return 32'hA0 + 32'(i);
    return (line ^ 32'hC0DE_0000) + 32'(i);
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem_word(a & ~32'h1F, int'(a[4:2]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one fetch, serve refill bursts until it hits, then check data and stall length.
  task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp,
                       input int exp_cyc, input int stall_n, input int inv_at);
    int          cyc;
    int          b;
    int          stalls;
    bit          done;
    bit          addr_seen;
    logic [31:0] line;
    logic [31:0] drop;
    cyc = 0; b = 0; stalls = 0; done = 1'b0; addr_seen = 1'b0;
    line = a & ~32'h1F;
    addr[d]   = a;
    rd_req[d] = 1'b1;
    exp_q.push_back(exp);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      inv[d]        = 1'b0;
      mem_rvalid[d] = 1'b0;
      mem_rlast[d]  = 1'b0;
      if (!miss[d]) begin
        chk($sformatf("rd_data@%h", a), rd_data[d], exp_q.pop_front());
        chk($sformatf("stall_cycles@%h", a), 32'(cyc), 32'(exp_cyc));
        done = 1'b1;
      end else begin
        inv[d] = (cyc == inv_at);
        if (!mem_read_req[d]) begin
          b = 0;
        end else begin
          if (!addr_seen) begin
            chk($sformatf("mem_addr@%h", a), mem_addr[d], line);
            addr_seen = 1'b1;
          end
          if (b == 4 && stalls < stall_n) begin
            stalls++;
          end else begin
            mem_rvalid[d] = 1'b1;
            mem_rdata[d]  = mem_word(line, b);
            mem_rlast[d]  = (b == 7);
            b++;
          end
        end
        cyc++;
      end
    end
    if (!done) begin
      chk($sformatf("fetch_done@%h", a), 32'(done), 32'd1);
      drop = exp_q.pop_front();
    end
    @(posedge clk);
    #1;
    rd_req[d]     = 1'b0;
    inv[d]        = 1'b0;
    mem_rvalid[d] = 1'b0;
    mem_rlast[d]  = 1'b0;
  endtask

  initial begin
    int bb;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; addr[d] = 32'h0; rd_req[d] = 1'b0; inv[d] = 1'b0;
      mem_rvalid[d] = 1'b0; mem_rdata[d] = 32'h0; mem_rlast[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    @(negedge clk);
    chk("reset_miss", 32'(miss[0]), 32'd0);
    chk("reset_mem_read_req", 32'(mem_read_req[0]), 32'd0);
    chk("reset_mem_addr", mem_addr[0], 32'h0);
    chk("reset_rd_data", rd_data[0], 32'h0);
    chk("reset_miss_4way", 32'(miss[1]), 32'd0);
    @(posedge clk);
    #1;

    // Cold miss, then a zero-latency hit on the last word of the same line.
    fetch(0, 32'h0000_1004, 32'hA1, 10, 0, -1);
    fetch(0, 32'h0000_101C, 32'hA7, 0, 0, -1);

    // LRU in set 0: tag 2 is evicted by tag 3 after tag 1 is touched.
    fetch(0, 32'h0000_2000, word_at(32'h2000), 10, 0, -1);
    fetch(0, 32'h0000_1000, 32'hA0, 0, 0, -1);
    fetch(0, 32'h0000_3000, word_at(32'h3000), 10, 0, -1);
    fetch(0, 32'h0000_1000, 32'hA0, 0, 0, -1);
    fetch(0, 32'h0000_2000, word_at(32'h2000), 10, 0, -1);

    // Three idle beats in the middle of a burst stretch the stall by three.
    fetch(0, 32'h0000_5008, word_at(32'h5008), 13, 3, -1);
    fetch(0, 32'h0000_5010, word_at(32'h5010), 0, 0, -1);

    // Invalidate in IDLE.
    inv[0] = 1'b1;
    @(posedge clk);
    #1;
    inv[0] = 1'b0;
    fetch(0, 32'h0000_5008, word_at(32'h5008), 10, 0, -1);

    // Invalidate during REFILL: installed line is dropped, so a second refill follows.
    fetch(0, 32'h0000_8004, word_at(32'h8004), 20, 0, 3);
    fetch(0, 32'h0000_8004, word_at(32'h8004), 0, 0, -1);

    // Miss and invalidate on the same IDLE edge.
    fetch(0, 32'h0000_7000, word_at(32'h7000), 10, 0, 0);
    fetch(0, 32'h0000_8004, word_at(32'h8004), 10, 0, -1);

    // Asynchronous reset after four beats of a refill.
    addr[0]   = 32'h0000_6000;
    rd_req[0] = 1'b1;
    bb = 0;
    for (int c = 0; c < 20 && bb < 4; c++) begin
      @(negedge clk);
      mem_rvalid[0] = 1'b0;
      if (mem_read_req[0]) begin
        mem_rvalid[0] = 1'b1;
        mem_rdata[0]  = mem_word(32'h6000, bb);
        mem_rlast[0]  = 1'b0;
        bb++;
      end
      @(posedge clk);
      #1;
    end
    chk("rst_burst_beats", 32'(bb), 32'd4);
    #2;
    rst[0]        = 1'b1;
    mem_rvalid[0] = 1'b0;
    #1;
    chk("rst_mem_read_req", 32'(mem_read_req[0]), 32'd0);
    chk("rst_mem_addr", mem_addr[0], 32'h0);
    rd_req[0] = 1'b0;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    fetch(0, 32'h0000_6000, word_at(32'h6000), 10, 0, -1);
    fetch(0, 32'h0000_7000, word_at(32'h7000), 10, 0, -1);

    // 4-way, 16 sets: five tags through set 0 evict only the first.
    for (int t = 1; t <= 5; t++) begin
      fetch(1, 32'(t) << 9, word_at(32'(t) << 9), 10, 0, -1);
    end
    for (int t = 2; t <= 5; t++) begin
      fetch(1, (32'(t) << 9) | 32'hC, word_at((32'(t) << 9) | 32'hC), 0, 0, -1);
    end
    fetch(1, 32'h0000_0200, word_at(32'h200), 10, 0, -1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised N-way set-associative, read-only instruction cache placed between the IF stage and the AXI read bridge. Lookup is combinational, so a hit returns the instruction in the same cycle. A miss refills one line through a word-serial burst: a single request is followed by `1<<(OFFSET_LEN-2)` data beats. Replacement is true LRU per set, and a global invalidate supports `cache`/`fence.i`-style flushes.

## Interface
Parameters:
- `OFFSET_LEN`, 5: byte-offset bits. Line holds `WORDS = 1<<(OFFSET_LEN-2)` 32-bit words.
- `INDEX_LEN`, 7: set-index bits. `SETS = 1<<INDEX_LEN`.
- `WAY_CNT`, 2: associativity. Must be a power of 2, range 1..8. `WAY_BITS = max(1, log2(WAY_CNT))`.
- `TAG_LEN`: derived, `32-INDEX_LEN-OFFSET_LEN`. Not overridable.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `addr` in 32: fetch address. Must be held stable while `miss`=1.
- `rd_req` in 1: fetch request.
- `rd_data` out 32: instruction word. Equals 0 when there is no hit.
- `miss` out 1: stall to the CPU.
- `inv` in 1: invalidate-all pulse.
- `mem_read_req` out 1: refill request. Level signal.
- `mem_addr` out 32: line-aligned refill address `{addr[31:OFFSET_LEN], 0}`. Equals 0 when `mem_read_req`=0.
- `mem_rvalid` in 1: refill beat valid.
- `mem_rdata` in 32: refill beat data.
- `mem_rlast` in 1: final beat. Qualified by `mem_rvalid`.

## Operation
Address fields:
- `tag = addr[31:32-TAG_LEN]`
- `index = addr[OFFSET_LEN+INDEX_LEN-1:OFFSET_LEN]`
- `word = addr[OFFSET_LEN-1:2]`

Storage:
- Tag, valid, data and LRU-age arrays are registers with asynchronous read and synchronous write.
- Reset clears every valid bit and sets the age of way `i` to `i` in every set.

Hit logic:
- `hit_way[i] = valid[i][index] && tag_arr[i][index]==tag`.
- At most one way hits. If more than one does, the lowest way index wins.

LRU (age counters, `WAY_BITS` each):
- On a hit to way `w` in state IDLE with `rd_req`=1, every way in the set with `age < age[w]` increments, and `age[w]` becomes 0.
- Installing a line into way `w` updates ages the same way.

Victim selection:
- The victim is the lowest-index invalid way in the set.
- If every way is valid, the victim is the way with `age == WAY_CNT-1`.
- The victim is latched when the miss is detected.

State machine:
- IDLE → REFILL when `rd_req && !hit`. At this edge: latch the victim, clear the victim's valid bit, and reset the beat counter to 0.
- REFILL: hold `mem_read_req`=1. On each beat with `mem_rvalid`=1, write `mem_rdata` into `data[victim][index][beat_cnt]` and increment `beat_cnt` (`OFFSET_LEN-2` bits, wraps). When `mem_rvalid && mem_rlast`, go to INSTALL.
- INSTALL: write the tag, set the valid bit, and update LRU for the victim. Then go to IDLE.
- IDLE only: if `inv`=1, clear all valid bits and reset ages at the edge. A `rd_req` in that same cycle is still served from the pre-flush contents.

`inv` outside IDLE:
- An `inv` pulse in REFILL or INSTALL sets a pending flag.
- The flag is applied on the IDLE-entry edge, so the freshly installed line is also invalidated, and the flag is then cleared.

`miss` is defined as `(state != IDLE) || (rd_req && !hit)`.

## Timing
- Reset values: `miss`=0, `mem_read_req`=0, `mem_addr`=0, `rd_data`=0, state IDLE, pending-invalidate flag 0.
- Hit latency: 0 cycles. `rd_data` is valid and `miss`=0 in the same cycle `rd_req` is asserted.
- Miss, with `mem_rvalid` continuously high:
  - C0: miss is detected.
  - C1 to C`WORDS`: REFILL beats.
  - C`WORDS+1`: INSTALL.
  - C`WORDS+2`: IDLE, and the access hits.
  - Total stall: `WORDS+2` cycles. For `WORDS`=8, `miss` is high for 10 cycles.
- Beat rules:
  - Beats with `mem_rvalid`=0 are ignored.
  - An `mem_rlast` arriving earlier than beat `WORDS-1` ends the refill anyway. The unwritten words are stale; this is a protocol violation and is not checked.
  - A `mem_rvalid` outside REFILL is ignored.
- Asynchronous `rst` mid-refill:
  - State returns to IDLE and all valid bits are cleared.
  - `mem_read_req` drops without waiting for a clock edge.
  - The bridge must discard the remainder of the burst.
- Simultaneous `rd_req` miss and `inv` in IDLE: the flush and the REFILL entry occur on the same edge, and the victim is way 0.

## Test plan
- Cold miss with `WAY_CNT`=2, address `0x0000_1004`:
  - `mem_read_req`=1 with `mem_addr`=`0x0000_1000`.
  - Feed 8 beats `0xA0..0xA7`.
  - Expect `miss` high for 10 cycles, then `rd_data`=`0xA1`. A subsequent read of `0x0000_101C` returns `0xA7` with 0 latency.
- LRU eviction: fill tags `0x1` and `0x2` in set 0, hit tag `0x1`, then miss on tag `0x3` → tag `0x2`'s way is replaced, and tag `0x1` still hits.
- Stalled burst: insert 3 idle cycles (`mem_rvalid`=0) between beats 3 and 4 → `miss` is extended by 3 cycles and the data is correct.
- Invalidate: pulse `inv` in IDLE → the next fetch of a previously cached address misses. Pulse `inv` during REFILL → the just-installed line misses on the cycle after INSTALL.
- Reset at beat 4 of a refill → `mem_read_req`=0 immediately. After release, the same address misses again.
- `WAY_CNT`=4, `INDEX_LEN`=4: cycle 5 distinct tags through one set → the first tag is evicted and the other 4 hit.
